// File: rtl/bsearch_pkg.sv
// Shared types for the binary search engine.
// FSM state encoding and search-mode constants.
package bsearch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMPARE,
    DONE
  } state_t;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LB    = 1'b1;

endpackage

// File: rtl/bsearch_window.sv
// Half-open search window [lo,hi) with probe midpoint and lb hit flag.
// Ports: clk/reset, init_i/step_lo_i/step_hi_i strobes, data_i/key_i
// compared on step_hi, lo_o/hi_o/mid_o window, hit_o, empty_o (lo==hi).
module bsearch_window
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_i,
  input  logic              step_lo_i,
  input  logic              step_hi_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] key_i,
  output logic [ADDR_W:0]   lo_o,
  output logic [ADDR_W:0]   hi_o,
  output logic [ADDR_W:0]   mid_o,
  output logic              hit_o,
  output logic              empty_o
);

  localparam int W = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0] lo_q, lo_d;
  logic [ADDR_W:0] hi_q, hi_d;
  logic            hit_q, hit_d;
  logic [ADDR_W:0] mid;

  // hi >= lo always holds, so the difference never wraps
  assign mid = lo_q + ((hi_q - lo_q) >> 1);

  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    hit_d = hit_q;
    if (init_i) begin
      lo_d  = '0;
      hi_d  = DEPTH;
      hit_d = 1'b0;
    end else if (step_lo_i) begin
      lo_d = mid + W'(1);
    end else if (step_hi_i) begin
      hi_d  = mid;
      hit_d = (data_i == key_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q  <= '0;
      hi_q  <= '0;
      hit_q <= 1'b0;
    end else begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      hit_q <= hit_d;
    end
  end

  assign lo_o    = lo_q;
  assign hi_o    = hi_q;
  assign mid_o   = mid;
  assign hit_o   = hit_q;
  assign empty_o = (lo_q == hi_q);

endmodule

// File: rtl/binary_search_engine.sv
// Binary search over a sorted synchronous memory, exact or lower-bound.
// Ports: clk, reset, start/lb_mode/target request, busy/done/found/loc
// result, mem_rd_en/mem_addr/mem_data read port with MEM_LAT latency.
module binary_search_engine
  import bsearch_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              lb_mode,
  input  logic [DATA_W-1:0] target,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W:0]   loc,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              mode_q, mode_d;
  logic              found_q, found_d;
  logic [ADDR_W:0]   loc_q, loc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic            win_init, step_lo, step_hi;
  logic [ADDR_W:0] lo, hi, mid;
  logic            hit, empty;

  bsearch_window #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_window (
    .clk       (clk),
    .reset     (reset),
    .init_i    (win_init),
    .step_lo_i (step_lo),
    .step_hi_i (step_hi),
    .data_i    (mem_data),
    .key_i     (key_q),
    .lo_o      (lo),
    .hi_o      (hi),
    .mid_o     (mid),
    .hit_o     (hit),
    .empty_o   (empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    mode_d    = mode_q;
    found_d   = found_q;
    loc_d     = loc_q;
    addr_d    = addr_q;
    win_init  = 1'b0;
    step_lo   = 1'b0;
    step_hi   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d    = target;
          mode_d   = lb_mode;
          found_d  = 1'b0;
          loc_d    = '0;
          win_init = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (empty) begin
          if (mode_q == MODE_LB) begin
            loc_d   = lo;
            found_d = hit;
          end else begin
            loc_d   = '0;
            found_d = 1'b0;
          end
          state_d = DONE;
        end else begin
          mem_rd_en = 1'b1;
          addr_d    = mid[ADDR_W-1:0];
          cnt_d     = '0;
          state_d   = (MEM_LAT > 1) ? WAIT : COMPARE;
        end
      end
      WAIT: begin
        busy = 1'b1;
        // WAIT spans MEM_LAT-1 cycles, counted 0..MEM_LAT-2
        if (int'(cnt_q) == MEM_LAT - 2) begin
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COMPARE: begin
        busy = 1'b1;
        if (mode_q == MODE_EXACT && mem_data == key_q) begin
          found_d = 1'b1;
          loc_d   = mid;
          state_d = DONE;
        end else if (mem_data < key_q) begin
          step_lo = 1'b1;
          state_d = ISSUE;
        end else begin
          step_hi = 1'b1;
          state_d = ISSUE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      mode_q  <= MODE_EXACT;
      found_q <= 1'b0;
      loc_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      found_q <= found_d;
      loc_q   <= loc_d;
      addr_q  <= addr_d;
    end
  end

  // Present the new probe address in the strobe cycle, then hold it
  assign mem_addr = mem_rd_en ? mid[ADDR_W-1:0] : addr_q;
  assign found    = found_q;
  assign loc      = loc_q;

endmodule

// File: tb/tb_binary_search_engine.sv
// Directed bench: two engines (MEM_LAT=1 and MEM_LAT=3) over one table.
// Checks results, probe addresses, probe counts and start->done cycles.
module tb_binary_search_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_s [2];
  logic       lb_s [2];
  logic [7:0] tgt_s [2];
  logic       busy_s [2];
  logic       done_s [2];
  logic       found_s [2];
  logic [5:0] loc_s [2];
  logic       rd_s [2];
  logic [4:0] addr_s [2];
  logic [7:0] mdata1;
  logic [7:0] mdata3;

  logic [7:0] mem [32];
  logic [2:0] v3;
  logic [4:0] a31, a32;

  int n_chk = 0;
  int n_err = 0;
  int q[$];

  always #5 clk = ~clk;

  binary_search_engine #(.DATA_W(8), .ADDR_W(5), .MEM_LAT(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .start     (start_s[0]),
    .lb_mode   (lb_s[0]),
    .target    (tgt_s[0]),
    .busy      (busy_s[0]),
    .done      (done_s[0]),
    .found     (found_s[0]),
    .loc       (loc_s[0]),
    .mem_rd_en (rd_s[0]),
    .mem_addr  (addr_s[0]),
    .mem_data  (mdata1)
  );

  binary_search_engine #(.DATA_W(8), .ADDR_W(5), .MEM_LAT(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .start     (start_s[1]),
    .lb_mode   (lb_s[1]),
    .target    (tgt_s[1]),
    .busy      (busy_s[1]),
    .done      (done_s[1]),
    .found     (found_s[1]),
    .loc       (loc_s[1]),
    .mem_rd_en (rd_s[1]),
    .mem_addr  (addr_s[1]),
    .mem_data  (mdata3)
  );

  // Memory models: data is valid only exactly LAT cycles after the
  // strobe; any other cycle returns junk.
  always @(posedge clk) begin
    mdata1 <= rd_s[0] ? mem[addr_s[0]] : 8'hA5;
  end

  always @(posedge clk) begin
    v3     <= {v3[1:0], rd_s[1]};
    a31    <= addr_s[1];
    a32    <= a31;
    mdata3 <= v3[1] ? mem[a32] : 8'h5A;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int s, input logic lb, input logic [7:0] t,
                     input bit ghost, output int cyc, output int np);
    q.delete();
    np  = 0;
    cyc = 0;
    @(negedge clk);
    start_s[s] = 1'b1;
    lb_s[s]    = lb;
    tgt_s[s]   = t;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start_s[s] = 1'b0;
    lb_s[s]    = ~lb;
    tgt_s[s]   = ~t;
    check("busy_after_start", int'(busy_s[s]), 1);
    while (!done_s[s] && cyc < 200) begin
      if (rd_s[s]) begin
        q.push_back(int'(addr_s[s]));
        np++;
      end
      start_s[s] = (ghost && cyc == 3);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start_s[s] = 1'b0;
    check("done_seen", int'(done_s[s]), 1);
    check("busy_in_done", int'(busy_s[s]), 0);
  endtask

  task automatic result(input int s, input string tag, input int f,
                        input int l, input int c, input int p,
                        input int cyc, input int np);
    check({tag, "_found"}, int'(found_s[s]), f);
    check({tag, "_loc"}, int'(loc_s[s]), l);
    check({tag, "_cycles"}, cyc, c);
    check({tag, "_probes"}, np, p);
    @(negedge clk);
    check({tag, "_done_1cyc"}, int'(done_s[s]), 0);
    check({tag, "_hold_loc"}, int'(loc_s[s]), l);
    check({tag, "_hold_found"}, int'(found_s[s]), f);
  endtask

  task automatic seq(input string tag, input int e[]);
    check({tag, "_nseq"}, q.size(), e.size());
    foreach (e[i]) begin
      if (i < q.size()) check({tag, "_addr"}, q[i], e[i]);
    end
  endtask

  initial begin
    int cyc, np, pulses;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      lb_s[i]    = 1'b0;
      tgt_s[i]   = 8'd0;
    end
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
    v3 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", int'(busy_s[i]), 0);
      check("rst_done", int'(done_s[i]), 0);
      check("rst_found", int'(found_s[i]), 0);
      check("rst_loc", int'(loc_s[i]), 0);
      check("rst_rd", int'(rd_s[i]), 0);
      check("rst_addr", int'(addr_s[i]), 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 1'b0, 8'd20, 1'b0, cyc, np);
    result(0, "ex20", 1, 10, 9, 4, cyc, np);
    seq("ex20", '{16, 8, 12, 10});

    run(0, 1'b0, 8'd21, 1'b0, cyc, np);
    result(0, "ex21", 0, 0, 12, 5, cyc, np);
    seq("ex21", '{16, 8, 12, 10, 11});

    run(0, 1'b1, 8'd21, 1'b0, cyc, np);
    result(0, "lb21", 0, 11, 12, 5, cyc, np);

    run(0, 1'b1, 8'd0, 1'b0, cyc, np);
    result(0, "lb0", 1, 0, 14, 6, cyc, np);
    seq("lb0", '{16, 8, 4, 2, 1, 0});

    run(0, 1'b1, 8'd255, 1'b0, cyc, np);
    result(0, "lb255", 0, 32, 12, 5, cyc, np);
    seq("lb255", '{16, 24, 28, 30, 31});

    run(1, 1'b0, 8'd20, 1'b0, cyc, np);
    result(1, "l3ex20", 1, 10, 17, 4, cyc, np);
    seq("l3ex20", '{16, 8, 12, 10});

    for (int i = 3; i <= 6; i++) mem[i] = 8'd7;

    run(0, 1'b1, 8'd7, 1'b0, cyc, np);
    result(0, "dup_lb", 1, 3, 12, 5, cyc, np);
    seq("dup_lb", '{16, 8, 4, 2, 3});

    run(0, 1'b0, 8'd7, 1'b0, cyc, np);
    result(0, "dup_ex", 1, 4, 7, 3, cyc, np);

    run(1, 1'b1, 8'd7, 1'b1, cyc, np);
    result(1, "l3dup_ghost", 1, 3, 22, 5, cyc, np);

    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);

    @(negedge clk);
    start_s[1] = 1'b1;
    lb_s[1]    = 1'b0;
    tgt_s[1]   = 8'd21;
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy_s[1]), 0);
    check("midrst_loc", int'(loc_s[1]), 0);
    check("midrst_found", int'(found_s[1]), 0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_s[1]) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    check("midrst_idle_rd", int'(rd_s[1]), 0);

    run(1, 1'b0, 8'd21, 1'b0, cyc, np);
    result(1, "l3ex21_after_rst", 0, 0, 22, 5, cyc, np);

    run(1, 1'b1, 8'd255, 1'b0, cyc, np);
    result(1, "l3lb255", 0, 32, 22, 5, cyc, np);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
